// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
// Builds with or without MULDIV_EARLY_OUT_EN; nothing here depends on it.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage port bundle of the multiply/divide unit; dbg_state mirrors the FSM.
// Builds with or without MULDIV_EARLY_OUT_EN.
interface muldiv_sequencer_if #(
    parameter int XLEN = muldiv_pkg::XLEN_DEFAULT
);
    // Handshake: start is taken only when the unit is IDLE and flush is low; stall
    // holds upstream while an accepted op runs, and done pulses for one cycle
    // with Result valid (Result then holds until the next done).
    logic                        start;
    logic [2:0]                  Funct3;
    logic [XLEN-1:0]             SrcA;
    logic [XLEN-1:0]             SrcB;
    logic                        flush;
    logic                        stall;
    logic                        busy;
    logic                        done;
    logic [XLEN-1:0]             Result;
    muldiv_pkg::muldiv_state_e   dbg_state;

    modport master (
        output start, Funct3, SrcA, SrcB, flush,
        input  stall, busy, done, Result, dbg_state
    );

    modport slave (
        input  start, Funct3, SrcA, SrcB, flush,
        output stall, busy, done, Result, dbg_state
    );

endinterface

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider with operand magnitude and final sign fix.
// MULDIV_EARLY_OUT_EN: multiplies report early_exit once the multiplier runs out of ones.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            special,
    output logic [XLEN-1:0] special_result,
    output logic            early_exit,
    output logic [XLEN-1:0] final_result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              sign_q, sign_d;
    logic [2:0]        op_q, op_d;

    logic              a_signed, b_signed, a_neg, b_neg, load_sign;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_sel;

    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_signed & src_a[XLEN-1];
        b_neg    = b_signed & src_b[XLEN-1];
        a_mag    = a_neg ? -src_a : src_a;
        b_mag    = b_neg ? -src_b : src_b;
        case (funct3)
            F3_MULH, F3_MULHSU, F3_DIV: load_sign = a_neg ^ b_neg;
            F3_REM:                     load_sign = a_neg;
            default:                    load_sign = 1'b0;
        endcase
    end

    // Divide by zero and signed overflow bypass the iteration entirely.
    always_comb begin
        special        = 1'b0;
        special_result = '0;
        if (funct3[2]) begin
            if (src_b == '0) begin
                special        = 1'b1;
                special_result = funct3[1] ? src_a : '1;
            end else if ((funct3 == F3_DIV || funct3 == F3_REM) &&
                         src_a == MIN_NEG && src_b == '1) begin
                special        = 1'b1;
                special_result = (funct3 == F3_DIV) ? MIN_NEG : '0;
            end
        end
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        op_d     = op_q;
        shifted  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
        diff     = {1'b0, shifted} - {2'b00, mcand_q[XLEN-1:0]};
        if (load) begin
            op_d     = funct3;
            sign_d   = load_sign;
            acc_d    = '0;
            mplier_d = funct3[2] ? a_mag : b_mag;
            mcand_d  = funct3[2] ? {{XLEN{1'b0}}, b_mag} : {{XLEN{1'b0}}, a_mag};
        end else if (step) begin
            if (!op_q[2]) begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end else if (!diff[XLEN+1]) begin
                // Dividend bits shift out of mplier_q while quotient bits shift in.
                acc_d    = {{(XLEN-1){1'b0}}, diff[XLEN:0]};
                mplier_d = {mplier_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d    = {{(XLEN-1){1'b0}}, shifted};
                mplier_d = {mplier_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_fixed = sign_q ? -acc_q : acc_q;
        div_sel    = op_q[1] ? acc_q[XLEN-1:0] : mplier_q;
        if (op_q[2]) begin
            final_result = sign_q ? -div_sel : div_sel;
        end else if (op_q == F3_MUL) begin
            final_result = prod_fixed[XLEN-1:0];
        end else begin
            final_result = prod_fixed[2*XLEN-1:XLEN];
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early_exit = !op_q[2] && (mplier_q[XLEN-1:1] == '0);
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            op_q     <= 3'b000;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            op_q     <= op_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: IDLE/CALC/FIX/DONE FSM, iteration counter, handshake.
// MULDIV_EARLY_OUT_EN lets multiplies leave CALC early (via the datapath's early_exit).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept, load, step;
    logic             special, early_exit;
    logic [XLEN-1:0]  special_result, final_result;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .step           (step),
        .funct3         (bus.Funct3),
        .src_a          (bus.SrcA),
        .src_b          (bus.SrcB),
        .special        (special),
        .special_result (special_result),
        .early_exit     (early_exit),
        .final_result   (final_result)
    );

    assign accept = (state_q == IDLE) && bus.start && !bus.flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_d  = DONE;
                        result_d = special_result;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(XLEN);
                        load    = 1'b1;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1) || early_exit) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                // Result only moves on the way into DONE, so a flush here leaves it intact.
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = final_result;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.stall     = accept || (state_q == CALC) || (state_q == FIX);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.Result    = result_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush/reset/busy corner sequences.
// Expected multiply latency follows MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
        string       name;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_q[$];
    logic [31:0] hold;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic special, input string name);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.special = special; v.name = name;
        vq.push_back(v);
    endtask

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] b,
                                       input logic special);
        logic [31:0] m;
        int          n;
        if (special) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3[2]) begin
            m = (f3 == F3_MULH && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            return n + 2;
        end
`else
        m = b;
        n = int'(m[0]);
`endif
        return 34;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
    endtask

    // Start at cycle N, count cycles to done, and count stall cycles over N..done.
    task automatic run_vec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input logic special, input string name);
        int          lat;
        int          stall_n;
        int          want;
        logic [31:0] sb_exp;
        want = exp_latency(f3, b, special);
        drive(f3, a, b);
        bus.start = 1'b1;
        exp_q.push_back(exp);
        #1;
        stall_n = bus.stall ? 1 : 0;
        cyc();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            if (bus.stall) stall_n++;
            cyc();
            lat++;
        end
        if (bus.stall) stall_n++;
        check({name, "_done"}, {31'b0, bus.done}, 32'd1);
        check({name, "_latency"}, lat, want);
        check({name, "_stall_cycles"}, stall_n, want);
        sb_exp = exp_q.pop_front();
        check({name, "_result"}, bus.Result, sb_exp);
        hold = exp;
        cyc();
        check({name, "_idle_after"}, {30'b0, bus.dbg_state}, {30'b0, IDLE});
    endtask

    initial begin
        bit seen;
        int cycles;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        drive(3'b000, 32'h0, 32'h0);
        repeat (3) cyc();
        check("reset_stall", {31'b0, bus.stall}, 32'd0);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.Result, 32'h0);
        check("reset_state", {30'b0, bus.dbg_state}, {30'b0, IDLE});
        reset = 1'b0;
        cyc();

        add(F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7_m3");
        add(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max");
        add(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhsu_m1");
        add(F3_DIV,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 1'b0, "div_m20_6");
        add(F3_REM,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 1'b0, "rem_m20_6");
        add(F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, "divu_by0");
        add(F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem_ovf");
        add(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf");
        add(F3_REM,    32'd7,        32'd0,        32'd7,        1'b1, "rem_by0");
        add(F3_DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 1'b1, "div_by0");
        add(F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulh_min_min");
        add(F3_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 1'b0, "mulh_m3_5");
        add(F3_MUL,    32'h12345678, 32'h10,       32'h23456780, 1'b0, "mul_shift4");
        add(F3_MULHU,  32'h80000000, 32'd2,        32'd1,        1'b0, "mulhu_carry");
        add(F3_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7");
        add(F3_REMU,   32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7");
        add(F3_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, "divu_max_1");
        add(F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_7_m2");
        add(F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, "rem_7_m2");
        add(F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, "rem_m7_2");
        add(F3_MUL,    32'd9,        32'd0,        32'd0,        1'b0, "mul_by0");

        foreach (vq[i]) run_vec(vq[i].f3, vq[i].a, vq[i].b, vq[i].exp, vq[i].special, vq[i].name);

        // Flush in CALC at N+10: back to IDLE at N+11, no done, Result held.
        drive(F3_DIV, 32'd100, 32'd7);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (bus.done) seen = 1'b1;
            cyc();
        end
        bus.flush = 1'b1;
        if (bus.done) seen = 1'b1;
        cyc();
        bus.flush = 1'b0;
        if (bus.done) seen = 1'b1;
        check("flush_calc_state", {30'b0, bus.dbg_state}, {30'b0, IDLE});
        check("flush_calc_busy", {31'b0, bus.busy}, 32'd0);
        check("flush_calc_no_done", {31'b0, seen}, 32'd0);
        check("flush_calc_result", bus.Result, hold);
        cyc();
        run_vec(F3_DIV, 32'd100, 32'd7, 32'd14, 1'b0, "div_after_flush");

        // start together with flush in IDLE is dropped.
        drive(F3_DIVU, 32'd9, 32'd0);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        #1;
        check("start_flush_stall", {31'b0, bus.stall}, 32'd0);
        cyc();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush_done", {31'b0, bus.done}, 32'd0);
        check("start_flush_busy", {31'b0, bus.busy}, 32'd0);
        cyc();

        // Flush in FIX: no done, Result held.
        drive(F3_DIVU, 32'd100, 32'd7);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (32) cyc();
        check("fix_reached", {30'b0, bus.dbg_state}, {30'b0, FIX});
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        check("flush_fix_done", {31'b0, bus.done}, 32'd0);
        check("flush_fix_state", {30'b0, bus.dbg_state}, {30'b0, IDLE});
        check("flush_fix_result", bus.Result, hold);
        cyc();

        // Flush in DONE is ignored.
        drive(F3_DIVU, 32'd200, 32'd7);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (33) cyc();
        bus.flush = 1'b1;
        check("flush_done_pulse", {31'b0, bus.done}, 32'd1);
        check("flush_done_result", bus.Result, 32'd28);
        cyc();
        bus.flush = 1'b0;
        check("flush_done_after_result", bus.Result, 32'd28);
        check("flush_done_after_busy", {31'b0, bus.busy}, 32'd0);
        hold = 32'd28;
        cyc();

        // start while busy is ignored; the original divide completes unchanged.
        drive(F3_DIVU, 32'd100, 32'd7);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (4) cyc();
        drive(F3_DIV, 32'd9, 32'd0);
        bus.start = 1'b1;
        repeat (3) cyc();
        bus.start = 1'b0;
        cycles = 0;
        while (!bus.done && cycles < 100) begin
            cyc();
            cycles++;
        end
        check("busy_start_latency", cycles + 8, 34);
        check("busy_start_result", bus.Result, 32'd14);
        cyc();
        check("busy_start_idle", {31'b0, bus.busy}, 32'd0);
        cyc();

        // Reset mid-operation clears everything.
        drive(F3_DIVU, 32'hFFFFFFFF, 32'd3);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("reset_mid_state", {30'b0, bus.dbg_state}, {30'b0, IDLE});
        check("reset_mid_result", bus.Result, 32'h0);
        check("reset_mid_stall", {31'b0, bus.stall}, 32'd0);
        cyc();
        run_vec(F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
